lcd_reader: RTL and testbench

- Nios II custom-instruction slave that reads from the HD44780 character LCD (RW=1). It complements the write-only LCD controller.
- Supports two operations:
  - Single read of the data register or the busy-flag/address register.
  - Busy-flag poll that repeats reads until BF=0 or a timeout.
- Shares the LCD pins with the write controller. The top level muxes rs/rw/en using `active`.

---
 rtl/lcd_reader_if.sv | 25 ++
 rtl/lcd_reader.sv | 146 ++++++++++++++
 tb/tb_lcd_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_reader_if.sv
// Custom-instruction handshake plus LCD read-side pins. The slave side is the reader and the master side drives it.
// rs/rw/en/active are meant to be muxed with the write controller at top level.
interface lcd_reader_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic        rs;
    logic        rw;
    logic        en;
    logic [7:0]  db_in;
    logic        active;

    modport master (
        output clk_en, start, dataa, datab, db_in,
        input  result, done, rs, rw, en, active
    );

    modport slave (
        input  clk_en, start, dataa, datab, db_in,
        output result, done, rs, rw, en, active
    );
endinterface

// File: rtl/lcd_reader.sv
// HD44780 read engine: single read (S+H+L+1 cycles) or BF poll (n*(S+H+L)+1 cycles, timeout at POLL_MAX).
// No backpressure; clk_en=0 freezes every register, and start is ignored unless IDLE.
module lcd_reader #(
    parameter int SETUP_CYC   = 4,
    parameter int EN_HIGH_CYC = 25,
    parameter int EN_LOW_CYC  = 25,
    parameter int POLL_MAX    = 2000
) (
    input  logic         clk,
    input  logic         reset,
    lcd_reader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        EN_HIGH = 3'd2,
        EN_LOW  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] HIGH_LAST  = 16'(EN_HIGH_CYC - 1);
    localparam logic [15:0] LOW_LAST   = 16'(EN_LOW_CYC - 1);
    localparam logic [15:0] POLL_LAST  = 16'(POLL_MAX - 1);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] poll_q, poll_d;
    logic        mode_q, mode_d;
    logic        rs_q, rs_d;
    logic        rw_q, rw_d;
    logic        en_q, en_d;
    logic [8:0]  res_q, res_d;

    wire unused_bits = ^{bus.dataa[31:1], bus.datab[31:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            poll_q  <= '0;
            mode_q  <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            en_q    <= 1'b0;
            res_q   <= '0;
        end else if (bus.clk_en) begin
            state_q <= state_d;
            phase_q <= phase_d;
            poll_q  <= poll_d;
            mode_q  <= mode_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            en_q    <= en_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        poll_d  = poll_q;
        mode_d  = mode_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        en_d    = en_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d   = bus.datab[0];
                    // BF lives behind RS=0, so polling always reads the instruction register
                    rs_d     = bus.datab[0] ? 1'b0 : bus.dataa[0];
                    rw_d     = 1'b1;
                    en_d     = 1'b0;
                    phase_d  = '0;
                    poll_d   = '0;
                    res_d[8] = 1'b0;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    en_d    = 1'b1;
                    phase_d = '0;
                    state_d = EN_HIGH;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end

            EN_HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    res_d[7:0] = bus.db_in;
                    en_d       = 1'b0;
                    phase_d    = '0;
                    state_d    = EN_LOW;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end

            EN_LOW: begin
                if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    if (!mode_q) begin
                        state_d = DONE;
                    end else if (!res_q[7]) begin
                        res_d[8] = 1'b0;
                        state_d  = DONE;
                    end else if (poll_q == POLL_LAST) begin
                        res_d[8] = 1'b1;
                        state_d  = DONE;
                    end else begin
                        poll_d  = poll_q + 16'd1;
                        state_d = SETUP;
                    end
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end

            DONE: begin
                rw_d    = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                rw_d    = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    assign bus.result = {23'd0, res_q};
    assign bus.done   = (state_q == DONE);
    assign bus.active = (state_q != IDLE);
    assign bus.rs     = rs_q;
    assign bus.rw     = rw_q;
    assign bus.en     = en_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed plus random checks of lcd_reader against a scan-the-bytes reference model.
module tb_lcd_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start, clk_en, sel;
    logic [31:0] dataa, datab;
    logic [7:0]  db;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] dbq[$];

    always #5 clk = ~clk;

    lcd_reader_if bd ();
    lcd_reader_if bt ();

    assign bd.start  = start & ~sel;
    assign bt.start  = start & sel;
    assign bd.clk_en = clk_en;
    assign bt.clk_en = clk_en;
    assign bd.dataa  = dataa;
    assign bt.dataa  = dataa;
    assign bd.datab  = datab;
    assign bt.datab  = datab;
    assign bd.db_in  = db;
    assign bt.db_in  = db;

    lcd_reader dut (.clk(clk), .reset(reset), .bus(bd.slave));
    lcd_reader #(.POLL_MAX(3)) dut_t (.clk(clk), .reset(reset), .bus(bt.slave));

    wire [31:0] o_result = sel ? bt.result : bd.result;
    wire        o_done   = sel ? bt.done   : bd.done;
    wire        o_rs     = sel ? bt.rs     : bd.rs;
    wire        o_rw     = sel ? bt.rw     : bd.rw;
    wire        o_en     = sel ? bt.en     : bd.en;
    wire        o_active = sel ? bt.active : bd.active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: one read per iteration; poll stops at the first byte with bit7 clear or after pmax reads.
    function automatic void model(input bit mode, input int pmax, output int iters, output logic [8:0] res);
        iters = 1;
        res   = {1'b0, dbq[0]};
        if (mode) begin
            for (int i = 0; i < dbq.size(); i++) begin
                if (!dbq[i][7]) begin
                    iters = i + 1; res = {1'b0, dbq[i]}; break;
                end
                if (i + 1 == pmax) begin
                    iters = pmax; res = {1'b1, dbq[i]}; break;
                end
            end
        end
    endfunction

    task automatic run_op(input bit s, input bit rsb, input bit mode,
                          input int stall_at, input int stall_len, input bit spam);
        int iters, lat, c, pulses, en_cyc, first_en, done_cyc, done_n, idx, post;
        logic [8:0] res;
        bit rs_bad, rw_bad, hi_bad, pen, exp_rs;
        model(mode, s ? 3 : 2000, iters, res);
        lat = iters * 54 + 1 + stall_len;
        exp_rs = mode ? 1'b0 : rsb;
        pulses = 0; en_cyc = 0; first_en = 0; done_cyc = 0; done_n = 0; idx = 0; post = 0;
        rs_bad = 0; rw_bad = 0; hi_bad = 0; pen = 0;
        sel = s;
        dataa = $urandom(); dataa[0] = rsb;
        datab = $urandom(); datab[0] = mode;
        db = dbq[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        chk("rs_cycle1", {31'd0, o_rs}, {31'd0, exp_rs});
        chk("rw_cycle1", {31'd0, o_rw}, 32'd1);
        while (c < lat + 10 && post < 3) begin
            if (o_en) begin
                en_cyc++;
                if (!pen) begin
                    pulses++;
                    if (first_en == 0) first_en = c;
                end
            end
            if (pen && !o_en) begin
                idx++;
                if (idx < dbq.size()) db = dbq[idx];
            end
            pen = o_en;
            if (o_active && o_rs !== exp_rs) rs_bad = 1;
            if (o_rw !== o_active) rw_bad = 1;
            if (o_result[31:9] !== 23'd0) hi_bad = 1;
            if (o_done === 1'b1) begin
                done_n++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0) post++;
            if (stall_len > 0 && c == stall_at) clk_en = 1'b0;
            if (stall_len > 0 && c == stall_at + stall_len) clk_en = 1'b1;
            start = (spam && (c == 12 || c == 40)) ? 1'b1 : 1'b0;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        clk_en = 1'b1;
        chk("done_cycle", done_cyc, lat);
        chk("done_count", done_n, 1);
        chk("en_pulses", pulses, iters);
        chk("en_high_cycles", en_cyc, iters * 25 + stall_len);
        chk("first_en_cycle", first_en, 5);
        chk("result", o_result, {23'd0, res});
        chk("rs_stable", {31'd0, rs_bad}, 32'd0);
        chk("rw_tracks_active", {31'd0, rw_bad}, 32'd0);
        chk("result_hi_zero", {31'd0, hi_bad}, 32'd0);
    endtask

    initial begin
        bit bad;
        bit s, m, r, sp;
        int len, sa, sl;
        logic [7:0] b;
        start = 1'b0; clk_en = 1'b1; dataa = '0; datab = '0; db = '0; sel = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_result", bd.result | bt.result, 32'd0);
        chk("rst_pins", {27'd0, bd.rs | bt.rs, bd.rw | bt.rw, bd.en | bt.en,
                         bd.done | bt.done, bd.active | bt.active}, 32'd0);
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({bd.rs, bd.rw, bd.en, bd.done, bd.active, bt.rs, bt.rw, bt.en, bt.done, bt.active} !== 10'd0
                || bd.result !== 32'd0 || bt.result !== 32'd0) bad = 1;
        end
        chk("idle_100", {31'd0, bad}, 32'd0);

        dbq = '{8'h41};
        run_op(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        dbq = '{8'h80, 8'h80, 8'h80, 8'h05};
        run_op(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        dbq = '{8'h8F, 8'h8F, 8'h8F, 8'h8F};
        run_op(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);

        // reset in the middle of the strobe
        sel = 1'b0; dataa = 32'd1; datab = 32'd0; db = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_reset_en", {31'd0, bd.en}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("reset_en", {31'd0, bd.en}, 32'd0);
        chk("reset_rw", {31'd0, bd.rw}, 32'd0);
        chk("reset_active", {31'd0, bd.active}, 32'd0);
        chk("reset_result", bd.result, 32'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bd.done !== 1'b0) bad = 1;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bd.done !== 1'b0 || bd.active !== 1'b0) bad = 1;
        end
        chk("no_done_after_reset", {31'd0, bad}, 32'd0);
        dbq = '{8'h5A};
        run_op(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

        dbq = '{8'h3C};
        run_op(1'b0, 1'b0, 1'b0, 10, 10, 1'b1);

        for (int k = 0; k < 16; k++) begin
            s  = 1'($urandom_range(0, 1));
            m  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            sp = 1'($urandom_range(0, 1));
            sa = $urandom_range(5, 20);
            sl = $urandom_range(0, 6);
            len = m ? (s ? 4 : $urandom_range(1, 5)) : 1;
            dbq.delete();
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom());
                if (!s && m && i == len - 1) b[7] = 1'b0;
                dbq.push_back(b);
            end
            run_op(s, r, m, sa, sl, sp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
